// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide sequencer: op encodings,
// shared-ALU conf codes, FSM state encodings and the iteration count.
package muldiv_seq_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00110;

   localparam int ITER_N = 32;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_PREP  = 3'd1;
   localparam state_t S_ITER  = 3'd2;
   localparam state_t S_FIXUP = 3'd3;
   localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/muldiv_fsm.sv
// Sequencer control: IDLE -> PREP -> ITER (ITER_N cycles) -> FIXUP -> DONE.
// The current state is exported so the datapath and checkers can observe it.
module muldiv_fsm
   import muldiv_seq_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   start,
   output state_t state,
   output logic   busy,
   output logic   done,
   output logic   alu_own
);

   state_t     state_nxt;
   logic [4:0] iter_cnt;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_PREP;
         S_PREP:  state_nxt = S_ITER;
         S_ITER:  if (iter_cnt == 5'(ITER_N - 1)) state_nxt = S_FIXUP;
         S_FIXUP: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         iter_cnt <= '0;
      end else begin
         state <= state_nxt;
         // Counter only runs inside ITER and is parked at 0 everywhere else.
         if (state == S_ITER) iter_cnt <= iter_cnt + 5'd1;
         else                 iter_cnt <= '0;
      end
   end

   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign alu_own = (state == S_ITER);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu into HI/LO. Borrows the shared ALU only while
// iterating; start is a level sampled in IDLE, done is a one-cycle pulse.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero,
   output logic             alu_own,
   output logic [4:0]       alu_conf,
   output logic             alu_sign,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_result
);

   state_t state;

   muldiv_fsm u_fsm (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .state   (state),
      .busy    (busy),
      .done    (done),
      .alu_own (alu_own)
   );

   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] opnd;   // multiplicand magnitude (mult) or divisor magnitude (div)
   logic [WIDTH-1:0] w_hi;   // acc (mult) / rem (div)
   logic [WIDTH-1:0] w_lo;   // mpl (mult) / quo (div)
   logic             neg_q, neg_r;

   logic             is_div, is_signed;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
   assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

   always_comb begin
      alu_conf = '0;
      alu_in1  = '0;
      alu_in2  = '0;
      if (alu_own) begin
         if (is_div) begin
            alu_conf = ALU_SUB;
            alu_in1  = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
            alu_in2  = opnd;
         end else begin
            // ALU stays owned on a zero multiplier bit; adding 0 keeps the shift uniform.
            alu_conf = ALU_ADD;
            alu_in1  = w_hi;
            alu_in2  = w_lo[0] ? opnd : '0;
         end
      end
   end

   assign alu_sign = 1'b0;

   logic mul_c, div_borrow, div_take;

   assign mul_c = (alu_in1[WIDTH-1] & alu_in2[WIDTH-1]) |
                  ((alu_in1[WIDTH-1] | alu_in2[WIDTH-1]) & ~alu_result[WIDTH-1]);
   assign div_borrow = (~alu_in1[WIDTH-1] & alu_in2[WIDTH-1]) |
                       (~(alu_in1[WIDTH-1] ^ alu_in2[WIDTH-1]) & alu_result[WIDTH-1]);
   // Bit 32 of the shifted remainder means it already exceeds any 32-bit divisor.
   assign div_take = w_hi[WIDTH-1] | ~div_borrow;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign prod_fix = neg_q ? -{w_hi, w_lo} : {w_hi, w_lo};
   assign quo_fix  = neg_q ? -w_lo : w_lo;
   assign rem_fix  = neg_r ? -w_hi : w_hi;

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         opnd        <= '0;
         w_hi        <= '0;
         w_lo        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q        <= op;
                  a_q         <= a;
                  b_q         <= b;
                  div_by_zero <= 1'b0;
               end
            end
            S_PREP: begin
               neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               neg_r <= is_signed & a_q[WIDTH-1];
               w_hi  <= '0;
               if (is_div) begin
                  opnd <= b_mag;
                  w_lo <= a_mag;
               end else begin
                  opnd <= a_mag;
                  w_lo <= b_mag;
               end
            end
            S_ITER: begin
               if (is_div) begin
                  w_hi <= div_take ? alu_result : {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
                  w_lo <= {w_lo[WIDTH-2:0], div_take};
               end else begin
                  {w_hi, w_lo} <= {mul_c, alu_result, w_lo[WIDTH-1:1]};
               end
            end
            S_FIXUP: begin
               if (is_div) begin
                  if (b_q == '0) begin
                     lo          <= '1;
                     hi          <= a_q;
                     div_by_zero <= 1'b1;
                  end else begin
                     lo <= quo_fix;
                     hi <= rem_fix;
                  end
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed test-plan vectors, randomized
// operations against an arithmetic reference model, overlap and reset abort.
module tb_muldiv_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero, alu_own, alu_sign;
   logic [31:0] hi, lo, alu_in1, alu_in2, alu_result;
   logic [4:0]  alu_conf;

   int n_checks = 0;
   int n_fail   = 0;

   logic [64:0] exp_q[$];
   logic [31:0] res_hi, res_lo;
   logic        res_dbz;

   muldiv_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero),
      .alu_own     (alu_own),
      .alu_conf    (alu_conf),
      .alu_sign    (alu_sign),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_result  (alu_result)
   );

   // Shared ALU stand-in: combinational add or subtract.
   assign alu_result = (alu_conf == 5'b00110) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: {div_by_zero, hi, lo} ----------------
   function automatic logic [64:0] ref_model(input logic [1:0] op_i, input logic [31:0] a_i,
                                             input logic [31:0] b_i);
      longint      sa, sb, q, r;
      logic [63:0] p;
      logic [31:0] uq, ur;
      sa = longint'($signed(a_i));
      sb = longint'($signed(b_i));
      case (op_i)
         2'b00: begin p = sa * sb; return {1'b0, p}; end
         2'b01: begin p = {32'b0, a_i} * {32'b0, b_i}; return {1'b0, p}; end
         default: begin
            if (b_i == 32'h0) return {1'b1, a_i, 32'hFFFF_FFFF};
            if (op_i == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               return {1'b0, r[31:0], q[31:0]};
            end
            uq = a_i / b_i;
            ur = a_i % b_i;
            return {1'b0, ur, uq};
         end
      endcase
   endfunction

   // ---------------- driver: one full operation with cycle monitor ----------------
   task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
      logic [64:0] exp_v;
      logic [4:0]  exp_conf;
      int          lat, own_cnt;
      exp_q.push_back(ref_model(op_i, a_i, b_i));
      exp_conf = op_i[1] ? 5'b00110 : 5'b00000;
      @(posedge clk); #1;
      start = 1'b1; op = op_i; a = a_i; b = b_i;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      lat = 0; own_cnt = 0;
      for (int k = 1; k <= 60 && lat == 0; k++) begin
         @(negedge clk);
         if (alu_own) own_cnt++;
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy cycle %0d: got %b expected 1", k, busy);
         end
         n_checks++;
         if ({alu_sign, alu_conf} !== {1'b0, (alu_own ? exp_conf : 5'b0)}) begin
            n_fail++; $display("FAIL alu_conf cycle %0d: got %b/%b own=%b", k, alu_sign, alu_conf, alu_own);
         end
         if (!alu_own) begin
            n_checks++;
            if ({alu_in1, alu_in2} !== 64'h0) begin
               n_fail++; $display("FAIL alu_idle_operands cycle %0d: got %h %h expected 0", k, alu_in1, alu_in2);
            end
         end
         if (k == 1) begin
            n_checks++;
            if (div_by_zero !== 1'b0) begin
               n_fail++; $display("FAIL dbz_clear_on_start: got %b expected 0", div_by_zero);
            end
         end
         if (done === 1'b1) lat = k;
      end
      exp_v = exp_q.pop_front();
      res_hi = hi; res_lo = lo; res_dbz = div_by_zero;
      n_checks++;
      if (lat != 35) begin
         n_fail++; $display("FAIL latency op=%0d: got %0d expected 35 (0 = timeout)", op_i, lat);
      end
      n_checks++;
      if (own_cnt != 32) begin
         n_fail++; $display("FAIL alu_own_cycles: got %0d expected 32", own_cnt);
      end
      n_checks++;
      if ({div_by_zero, hi, lo} !== exp_v) begin
         n_fail++;
         $display("FAIL result op=%0d a=%h b=%h: got dbz=%b hi=%h lo=%h expected dbz=%b hi=%h lo=%h",
                  op_i, a_i, b_i, div_by_zero, hi, lo, exp_v[64], exp_v[63:32], exp_v[31:0]);
      end
      @(negedge clk);
      n_checks++;
      if ({done, busy, div_by_zero, hi, lo} !== {2'b00, exp_v}) begin
         n_fail++; $display("FAIL hold_after_done: got done=%b busy=%b hi=%h lo=%h", done, busy, hi, lo);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({busy, done, div_by_zero, alu_own, alu_sign} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, div_by_zero, alu_own, alu_sign});
      end
      n_checks++;
      if ({hi, lo} !== 64'h0) begin
         n_fail++; $display("FAIL reset_hilo: got %h %h expected 0", hi, lo);
      end
      n_checks++;
      if ({alu_conf, alu_in1, alu_in2} !== 69'h0) begin
         n_fail++; $display("FAIL reset_alu: got %b %h %h expected 0", alu_conf, alu_in1, alu_in2);
      end
   endtask

   task automatic test_directed();
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_checks++;
      if ({res_dbz, res_hi, res_lo} !== {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}) begin
         n_fail++; $display("FAIL multu_max: got %h %h", res_hi, res_lo);
      end
      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
      n_checks++;
      if ({res_dbz, res_hi, res_lo} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
         n_fail++; $display("FAIL mult_neg3x5: got %h %h", res_hi, res_lo);
      end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      n_checks++;
      if ({res_dbz, res_hi, res_lo} !== {1'b0, 32'h0, 32'h8000_0000}) begin
         n_fail++; $display("FAIL div_overflow: got dbz=%b %h %h", res_dbz, res_hi, res_lo);
      end
      run_op(2'b11, 32'd100, 32'd7);
      n_checks++;
      if ({res_dbz, res_hi, res_lo} !== {1'b0, 32'h2, 32'hE}) begin
         n_fail++; $display("FAIL divu_100_7: got %h %h", res_hi, res_lo);
      end
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      n_checks++;
      if ({res_dbz, res_hi, res_lo} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
         n_fail++; $display("FAIL div_neg7_2: got %h %h", res_hi, res_lo);
      end
      run_op(2'b10, 32'h1234_5678, 32'h0);
      n_checks++;
      if ({res_dbz, res_hi, res_lo} !== {1'b1, 32'h1234_5678, 32'hFFFF_FFFF}) begin
         n_fail++; $display("FAIL div_by_zero: got dbz=%b %h %h", res_dbz, res_hi, res_lo);
      end
   endtask

   task automatic test_random();
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      for (int i = 0; i < 24; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         case ($urandom_range(0, 7))
            0:       r_b = 32'h0;
            1:       r_b = 32'($urandom_range(1, 15));
            2:       r_b = 32'hFFFF_FFFF;
            3:       begin r_a = 32'h8000_0000; r_b = $urandom; end
            default: r_b = $urandom;
         endcase
         run_op(r_op, r_a, r_b);
      end
   endtask

   task automatic test_back_to_back();
      logic [64:0] exp_v;
      int          n_done, done_k;
      logic [64:0] got_v;
      exp_q.push_back(ref_model(2'b11, 32'd1000, 32'd3));
      @(posedge clk); #1;
      start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      n_done = 0; done_k = 0; got_v = '0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            if (n_done == 1) begin done_k = k; got_v = {div_by_zero, hi, lo}; end
         end
         @(posedge clk); #1;
         if (k + 1 == 10) begin
            start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0000_1234;
         end else begin
            start = 1'b0;
         end
      end
      exp_v = exp_q.pop_front();
      n_checks++;
      if (n_done != 1 || done_k != 35) begin
         n_fail++; $display("FAIL b2b_single_done: got %0d dones first at %0d expected 1 at 35", n_done, done_k);
      end
      n_checks++;
      if (got_v !== exp_v) begin
         n_fail++; $display("FAIL b2b_result: got %h expected %h", got_v, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      int n_done;
      run_op(2'b01, 32'h0001_0003, 32'h0002_0005);
      @(posedge clk); #1;
      start = 1'b1; op = 2'b00; a = 32'h7654_3210; b = 32'hFFFF_0011;
      @(posedge clk); #1;
      start = 1'b0;
      n_done = 0;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
         if (k == 12) begin
            n_checks++;
            if (alu_own !== 1'b1) begin
               n_fail++; $display("FAIL abort_in_iter: got alu_own=%b expected 1", alu_own);
            end
         end
         if (k == 13) begin
            n_checks++;
            if ({busy, alu_own, done, hi, lo} !== 67'h0) begin
               n_fail++; $display("FAIL abort_cleared: got busy=%b own=%b done=%b hi=%h lo=%h",
                                  busy, alu_own, done, hi, lo);
            end
         end
         @(posedge clk); #1;
         reset = (k + 1 == 12);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) n_done++;
      end
      n_checks++;
      if (n_done != 0) begin
         n_fail++; $display("FAIL abort_no_done: got %0d done/busy cycles expected 0", n_done);
      end
      run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
